// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver:
// scan FSM state encoding, the hex-to-segment table and a width helper.
package seg7_scan_driver_pkg;

    // Scan FSM: each digit slot opens with a dark blanking interval, then shows.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module seg7_scan_driver_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup; polarity is applied by the caller.
    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment display driver. Scans NDIGITS digits, one slot of
// PRESCALE clocks per digit, with a BLANK-clock dark interval at the start of
// each slot so no two digits are ever driven in adjacent clocks. Brightness is
// set by comparing a free-running PWM counter against brightness_i. Display
// data is staged on load_i and copied to the shadow only at a frame boundary,
// so a frame never shows a mix of old and new digits.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NDIGITS    = 2,
    parameter int PRESCALE   = 1024,
    parameter int BLANK      = 16,
    parameter int BW         = 4,
    parameter bit DIG_ACT_LO = 1'b1,
    parameter bit SEG_ACT_LO = 1'b0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [4*NDIGITS-1:0]   digits_i,
    input  logic [NDIGITS-1:0]     dp_i,
    input  logic                   load_i,
    input  logic [BW-1:0]          brightness_i,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [NDIGITS-1:0]     dig_o,
    output logic                   frame_o
);

    localparam int TW = width_for(PRESCALE);
    localparam int IW = width_for(NDIGITS);

    localparam logic [TW-1:0]      TIMER_LAST = TW'(PRESCALE - 1);
    localparam logic [TW-1:0]      BLANK_LAST = TW'(BLANK - 1);
    localparam logic [IW-1:0]      IDX_LAST   = IW'(NDIGITS - 1);

    // Inactive levels; XOR with these turns an active-high pattern into the
    // pin polarity.
    localparam logic [NDIGITS-1:0] DIG_OFF = DIG_ACT_LO ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};
    localparam logic [6:0]         SEG_OFF = SEG_ACT_LO ? 7'h7F : 7'h00;
    localparam logic               DP_OFF  = SEG_ACT_LO;

    // Scan state
    logic [TW-1:0]        r_timer;
    logic [IW-1:0]        r_idx;
    scan_state_e          r_state;
    logic [TW-1:0]        w_timer_next;
    logic [IW-1:0]        w_idx_next;
    scan_state_e          w_state_next;
    logic                 w_slot_end;
    logic                 w_frame_start;

    // PWM
    logic [BW-1:0]        r_pwm;
    logic                 w_lit;

    // Display data: staged (written by load_i) and shadow (being displayed)
    logic [4*NDIGITS-1:0] r_staged_digits;
    logic [NDIGITS-1:0]   r_staged_dp;
    logic                 r_pending;
    logic [4*NDIGITS-1:0] r_shadow_digits;
    logic [NDIGITS-1:0]   r_shadow_dp;

    // Output path
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg_raw;
    logic [NDIGITS-1:0]   w_dig_onehot;
    logic                 r_frame;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [NDIGITS-1:0]   r_dig;

    assign w_slot_end    = (r_timer == TIMER_LAST);
    assign w_frame_start = w_slot_end && (r_idx == IDX_LAST);

    // State register: slot timer, digit index and BLANK/SHOW phase.
    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= ST_BLANK;
        end else begin
            r_timer <= w_timer_next;
            r_idx   <= w_idx_next;
            r_state <= w_state_next;
        end
    end

    // Next-state logic: advance the timer, step the digit at slot end, and
    // enter SHOW once the blanking interval has elapsed.
    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_timer_next = r_timer + 1'b1;
        w_idx_next   = r_idx;
        w_state_next = ST_BLANK;
        if (w_slot_end) begin
            w_timer_next = '0;
            w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            w_state_next = ST_BLANK;
        end else if (r_timer >= BLANK_LAST) begin
            w_state_next = ST_SHOW;
        end
    end

    // Free-running PWM counter; compared against brightness_i every clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Segments light only in SHOW and only during the PWM on-time; all-ones
    // brightness means permanently on rather than one dark step per period.
    assign w_lit = (r_state == ST_SHOW) && ((&brightness_i) || (r_pwm < brightness_i));

    // Double buffer: load_i stages data; the shadow takes it at frame start.
    // A load landing exactly on the frame-start edge goes straight to the
    // shadow so it is shown in the frame that is just beginning.
    // NOTE: staged and shadow are small register banks, not RAM, and are cleared
    // on reset so the first frame after reset shows a defined value (all zero).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_staged_digits <= '0;
            r_staged_dp     <= '0;
            r_pending       <= 1'b0;
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
        end else if (w_frame_start && load_i) begin
            r_shadow_digits <= digits_i;
            r_shadow_dp     <= dp_i;
            r_pending       <= 1'b0;
        end else begin
            if (w_frame_start && r_pending) begin
                r_shadow_digits <= r_staged_digits;
                r_shadow_dp     <= r_staged_dp;
                r_pending       <= 1'b0;
            end
            if (load_i) begin
                r_staged_digits <= digits_i;
                r_staged_dp     <= dp_i;
                r_pending       <= 1'b1;
            end
        end
    end

    // Select the current digit's nibble and build its one-hot select.
    assign w_nibble     = r_shadow_digits[{r_idx, 2'b00} +: 4];
    assign w_dig_onehot = NDIGITS'(1) << r_idx;

    seg7_scan_driver_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_raw)
    );

    // Registered outputs, one clock behind the scan state; reset drives every
    // pin to its inactive level immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_frame <= 1'b0;
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_dig   <= DIG_OFF;
        end else begin
            r_frame <= w_frame_start;
            r_seg   <= w_lit ? (w_seg_raw ^ SEG_OFF) : SEG_OFF;
            r_dp    <= w_lit ? (r_shadow_dp[r_idx] ^ DP_OFF) : DP_OFF;
            r_dig   <= w_lit ? (w_dig_onehot ^ DIG_OFF) : DIG_OFF;
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign dig_o   = r_dig;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NDIGITS=2, PRESCALE=32, BLANK=4, BW=4,
// digits active-low, segments active-high). The stimulus process pushes the
// expected content of upcoming frames; the monitor samples every negedge,
// rebuilds the expected pin values for each position of a frame and compares.
// Digit 0 is the low nibble of digits_i, so the display "12" (digit0 shows 1,
// digit1 shows 2) is driven as 8'h21.
module tb_seg7_scan_driver;

    typedef struct {
        int         frame;
        logic [7:0] digits;
        logic [1:0] dp;
        logic [3:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] digits;
    logic [1:0] dp;
    logic       ld;
    logic [3:0] bright;
    logic [6:0] seg;
    logic       dpo;
    logic [1:0] dig;
    logic       frame;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Monitor state
    int   frames_opened = 0;
    int   cur_id = 0;
    bit   in_frame = 1'b0;
    bit   cur_valid = 1'b0;
    exp_t cur;
    int   pos = 0;
    int   mism = 0;
    int   first_bad = 0;
    int   onehot_viol = 0;
    int   adj_viol = 0;
    int   reset_viol = 0;

    seg7_scan_driver #(
        .NDIGITS    (2),
        .PRESCALE   (32),
        .BLANK      (4),
        .BW         (4),
        .DIG_ACT_LO (1'b1),
        .SEG_ACT_LO (1'b0)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .digits_i     (digits),
        .dp_i         (dp),
        .load_i       (ld),
        .brightness_i (bright),
        .seg_o        (seg),
        .dp_o         (dpo),
        .dig_o        (dig),
        .frame_o      (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // ---------------- monitor ----------------

    task open_frame();
        exp_t e;
        frames_opened++;
        cur_id    = frames_opened;
        in_frame  = 1'b1;
        pos       = 0;
        mism      = 0;
        first_bad = 0;
        cur_valid = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].frame < cur_id) begin
            e = exp_q.pop_front();
            check("expected_frame_seen", cur_id, e.frame);
        end
        if (exp_q.size() > 0 && exp_q[0].frame == cur_id) begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
        end
    endtask

    task close_frame();
        check($sformatf("frame%0d_length", cur_id), pos, 64);
        if (cur_valid)
            check($sformatf("frame%0d_content_first_bad_pos%0d", cur_id, first_bad), mism, 0);
    endtask

    // Sample at frame position pos reflects internal slot (pos-1): digit
    // (pos-1)/32, timer (pos-1)%32; the PWM counter equals timer%16.
    task compare_sample();
        int         q;
        int         idx;
        int         t;
        bit         lit;
        logic [1:0] e_dig;
        logic [6:0] e_seg;
        logic       e_dp;
        q   = pos - 1;
        idx = q / 32;
        t   = q % 32;
        lit = (t >= 4) && (cur.b == 4'hF || (t % 16) < int'(cur.b));
        if (q >= 64) begin
            e_dig = 2'bxx;
            e_seg = 7'bx;
            e_dp  = 1'bx;
            mism++;
            if (first_bad == 0) first_bad = pos;
        end else begin
            e_dig = lit ? ((idx == 0) ? 2'b10 : 2'b01) : 2'b11;
            e_seg = lit ? seg_of((idx == 0) ? cur.digits[3:0] : cur.digits[7:4]) : 7'b0;
            e_dp  = lit ? cur.dp[idx] : 1'b0;
            if (dig !== e_dig || seg !== e_seg || dpo !== e_dp) begin
                mism++;
                if (first_bad == 0) first_bad = pos;
            end
        end
    endtask

    initial begin : monitor
        bit         prev_rst;
        logic [1:0] prev_dig;
        prev_rst = 1'b1;
        prev_dig = 2'b11;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (dig !== 2'b11 || seg !== 7'b0 || dpo !== 1'b0 || frame !== 1'b0) reset_viol++;
                in_frame  = 1'b0;
                cur_valid = 1'b0;
                prev_rst  = 1'b1;
            end else if (prev_rst) begin
                // First sample after release: a new frame starts without frame_o.
                prev_rst = 1'b0;
                open_frame();
            end else begin
                if (in_frame) begin
                    pos++;
                    if (cur_valid) compare_sample();
                end
                if (frame === 1'b1) begin
                    if (in_frame) close_frame();
                    open_frame();
                end
            end
            if ($countones(~dig) > 1) onehot_viol++;
            if (dig !== 2'b11 && prev_dig !== 2'b11 && dig !== prev_dig) adj_viol++;
            prev_dig = dig;
        end
    end

    // ---------------- stimulus ----------------

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int f, input logic [7:0] d, input logic [1:0] p, input logic [3:0] b);
        exp_t e;
        e.frame  = f;
        e.digits = d;
        e.dp     = p;
        e.b      = b;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] d, input logic [1:0] p);
        digits = d;
        dp     = p;
        ld     = 1'b1;
        cycles(1);
        ld     = 1'b0;
    endtask

    // Returns one clock after frame_o, at internal slot position 1.
    task automatic next_frame(output int f);
        int start;
        start = frames_opened;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (frames_opened != start) break;
        end
        check("frame_arrival", frames_opened > start, 1);
        f = frames_opened;
        #1;
    endtask

    initial begin : stimulus
        int f;
        int r;
        rst    = 1'b1;
        digits = 8'h00;
        dp     = 2'b00;
        ld     = 1'b0;
        bright = 4'hF;
        cycles(3);

        // Reset state and first load: the post-reset frame shows 00, the load
        // made during it shows from the first frame_o on.
        r = frames_opened + 1;
        push_exp(r,     8'h00, 2'b00, 4'hF);
        push_exp(r + 1, 8'h21, 2'b10, 4'hF);
        rst = 1'b0;
        cycles(5);
        load(8'h21, 2'b10);

        next_frame(f);
        push_exp(f + 1, 8'h21, 2'b10, 4'hF);

        // Tearing: a mid-frame load only appears at the next boundary.
        next_frame(f);
        push_exp(f + 1, 8'h43, 2'b01, 4'hF);
        cycles(9);
        load(8'h43, 2'b01);

        // Two loads in one frame: the last one wins.
        next_frame(f);
        push_exp(f + 1, 8'h65, 2'b11, 4'hF);
        cycles(9);
        load(8'h87, 2'b00);
        cycles(40);
        load(8'h65, 2'b11);

        // Load coincident with the frame-start transition (slot position 63).
        next_frame(f);
        push_exp(f + 1, 8'hBA, 2'b01, 4'hF);
        cycles(62);
        load(8'hBA, 2'b01);

        // PWM at brightness 4; the bypassed load must leave nothing pending.
        next_frame(f);
        push_exp(f + 1, 8'hBA, 2'b01, 4'h4);
        cycles(63);
        bright = 4'h4;

        // Brightness 0: dark display, frame_o keeps its 64-clock period.
        next_frame(f);
        push_exp(f + 1, 8'hBA, 2'b01, 4'h0);
        cycles(63);
        bright = 4'h0;

        next_frame(f);
        push_exp(f + 1, 8'hBA, 2'b01, 4'hF);
        cycles(63);
        bright = 4'hF;

        // Asynchronous reset in the middle of digit 0's SHOW phase, with a
        // staged load pending that reset must discard.
        next_frame(f);
        cycles(15);
        load(8'hFE, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dig", dig, 2'b11);
        check("async_rst_seg", seg, 7'b0);
        check("async_rst_dp", dpo, 1'b0);
        check("async_rst_frame", frame, 1'b0);
        cycles(2);
        r = frames_opened + 1;
        push_exp(r,     8'h00, 2'b00, 4'hF);
        push_exp(r + 1, 8'h00, 2'b00, 4'hF);
        rst = 1'b0;
        cycles(2);
        next_frame(f);
        next_frame(f);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        check("expectations_drained", exp_q.size(), 0);
        check("dig_multi_hot_samples", onehot_viol, 0);
        check("dig_adjacent_digit_samples", adj_viol, 0);
        check("outputs_active_in_reset", reset_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
